// File: rtl/scale_pkg.sv
// scale_pkg: shared defaults, FSM state type and ID-width helper for scale_sched.
// Contents:
//   DATA_WIDTH_DEF / FRAC_DEF : default word width and fractional bits
//   state_t                   : output slot state (EMPTY, FULL)
//   id_w(n)                   : width of a requester index for n requesters
package scale_pkg;
    localparam int DATA_WIDTH_DEF = 20;
    localparam int FRAC_DEF       = 16;

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/scale_core.sv
// scale_core: combinational shift-add scaler (a*0.6875) with optional negate.
// Ports:
//   i_a   : signed fixed-point operand
//   i_neg : negate the scaled result
//   o_y   : scaled (and optionally negated) result, wrapping
// Macro SCALE_TWOS_NEG_EN: negate as two's complement; otherwise one's complement.
import scale_pkg::*;

module scale_core #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic                  i_neg,
    output logic [DATA_WIDTH-1:0] o_y
);
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] scaled;

    always_comb begin
        a_s    = i_a;
        scaled = (a_s >>> 1) + (a_s >>> 3) + (a_s >>> 4);
`ifdef SCALE_TWOS_NEG_EN
        o_y    = i_neg ? -scaled : scaled;
`else
        o_y    = i_neg ? ~scaled : scaled;
`endif
    end
endmodule

// File: rtl/scale_sched.sv
// scale_sched: round-robin arbiter feeding a one-deep registered scaler output slot.
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_req_valid/data/neg      : per-requester valid, packed signed operand, negate select
//   o_req_ready               : one-hot grant (zero when the slot cannot accept)
//   o_out_valid/data/id       : registered result and the index that produced it
//   i_out_ready               : consumer accepts the result
// Macro SCALE_TWOS_NEG_EN (in scale_core): two's-complement negate instead of one's.
import scale_pkg::*;

module scale_sched #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int N_REQ      = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]            i_req_neg,
    output logic [N_REQ-1:0]            o_req_ready,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [DATA_WIDTH-1:0]       o_out_data,
    output logic [id_w(N_REQ)-1:0]      o_out_id
);
    localparam int IW = id_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || FRAC > DATA_WIDTH) begin : g_bad_cfg
        $error("scale_sched: illegal parameter combination");
    end

    state_t                state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    logic [IW-1:0]         id_q, id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         gnt_id, idx;
    logic                  found, free, xfer, neg_sel;
    logic [DATA_WIDTH-1:0] op, core_y;

    scale_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .i_a   (op),
        .i_neg (neg_sel),
        .o_y   (core_y)
    );

    always_comb begin
        free   = (state_q == EMPTY) || i_out_ready;
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        // Search begins one past the last winner so every requester gets a turn.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % N_REQ);
            if (!found && i_req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        // Gating with i_rst_n keeps grants low during the reset cycle.
        xfer        = free && found && i_rst_n;
        o_req_ready = xfer ? (N_REQ'(1) << gnt_id) : '0;
        op          = DATA_WIDTH'(i_req_data >> (int'(gnt_id) * DATA_WIDTH));
        neg_sel     = i_req_neg[gnt_id];
        // A drain and a new transfer in the same cycle keep the slot FULL.
        state_d     = xfer ? FULL : (i_out_ready ? EMPTY : state_q);
        data_d      = xfer ? core_y : data_q;
        id_d        = xfer ? gnt_id : id_q;
        last_d      = xfer ? gnt_id : last_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign o_out_valid = (state_q == FULL);
    assign o_out_data  = data_q;
    assign o_out_id    = id_q;
endmodule

// File: tb/tb_scale_sched.sv
// tb_scale_sched: randomized scoreboard bench for scale_sched with an arithmetic reference model.
module tb_scale_sched;
    localparam int N  = 4;
    localparam int DW = 20;
    localparam int IW = 2;
`ifdef SCALE_TWOS_NEG_EN
    localparam logic [DW-1:0] NEG_EXP = 20'hF5000;
`else
    localparam logic [DW-1:0] NEG_EXP = 20'hF4FFF;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_neg = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;

    always #5 clk = ~clk;

    scale_sched #(.DATA_WIDTH(DW), .FRAC(16), .N_REQ(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_neg   (req_neg),
        .o_req_ready (req_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_id    (out_id)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_full = 1'b0;
    int   m_last = N - 1;

    function automatic longint fdiv(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // 0.5 + 0.125 + 0.0625 of the operand, each term floored, then wrapped.
    function automatic logic [DW-1:0] scale_ref(input logic [DW-1:0] a, input logic neg);
        longint x, s;
        x = longint'($signed(a));
        s = fdiv(x, 2) + fdiv(x, 8) + fdiv(x, 16);
`ifdef SCALE_TWOS_NEG_EN
        if (neg) s = -s;
`else
        if (neg) s = -s - 1;
`endif
        return DW'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] ng,
                        input logic [N*DW-1:0] d, input logic rdy, output int g);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_neg   = ng;
        req_data  = d;
        out_ready = rdy;
        #2;
        g = -1;
        if (!m_full || rdy)
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (g < 0 && v[k]) g = k;
            end
        chk("valid", 64'(out_valid), 64'(m_full));
        chk("ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            e.d  = scale_ref(d[g*DW +: DW], ng[g]);
            e.id = IW'(g);
            sb.push_back(e);
            m_last = g;
            m_full = 1'b1;
        end else if (rdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = '1;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        sb.delete();
        m_full = 1'b0;
        m_last = N - 1;
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got data 0x%0h id %0d expected no output", out_data, out_id);
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0].d));
                    chk("out_id", 64'(out_id), 64'(sb[0].id));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int            g;
        logic [N*DW-1:0] d;
        logic [DW-1:0] s_d;
        logic [IW-1:0] s_id;
        do_reset();

        d = '0;
        d[2*DW +: DW] = 20'h10000;
        step(4'b0100, 4'b0000, d, 1'b1, g);
        chk("single_grant", 64'(g), 64'd2);
        step('0, '0, '0, 1'b0, g);
        chk("single_data", 64'(out_data), 64'h0B000);
        chk("single_id", 64'(out_id), 64'd2);

        step(4'b0100, 4'b0100, d, 1'b1, g);
        step('0, '0, '0, 1'b0, g);
        chk("neg_data", 64'(out_data), 64'(NEG_EXP));
        d[2*DW +: DW] = 20'hF0000;
        step(4'b0100, 4'b0000, d, 1'b1, g);
        step('0, '0, '0, 1'b0, g);
        chk("negop_data", 64'(out_data), 64'hF5000);

        do_reset();
        for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom);
        for (int i = 0; i < 5; i++) begin
            step('1, '0, d, 1'b1, g);
            chk("rr_grant", 64'(g), 64'(i % N));
        end

        step('1, '0, d, 1'b0, g);
        chk("stall_grant", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
        s_d  = out_data;
        s_id = out_id;
        for (int i = 0; i < 2; i++) begin
            step('1, '0, d, 1'b0, g);
            chk("stall_data", 64'(out_data), 64'(s_d));
            chk("stall_id", 64'(out_id), 64'(s_id));
        end
        step('1, '0, d, 1'b1, g);
        chk("refill_grant", 64'(g), 64'd1);

        step('1, '0, d, 1'b0, g);
        do_reset();
        step('1, '0, d, 1'b1, g);
        chk("post_rst_grant", 64'(g), 64'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom);
            step(N'($urandom), N'($urandom), d, $urandom_range(0, 3) != 0, g);
        end

        for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, g);
        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scale_sched.md
SCALE_SCHED -- requirements
Module: scale_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, meaning signed fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 16, meaning fractional bits; informational only, no effect on arithmetic.
REQ-003 SHALL have parameter N_REQ, default 4, meaning number of requesters, legal range 2..8.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port i_req_valid, input, N_REQ bits: per-requester request valid.
REQ-007 SHALL have port i_req_data, input, N_REQ*DATA_WIDTH bits: packed signed operands; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port i_req_neg, input, N_REQ bits: per-requester negate select.
REQ-009 SHALL have port o_req_ready, output, N_REQ bits: one-hot grant, or all zero.
REQ-010 SHALL have port o_out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port i_out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port o_out_data, output, DATA_WIDTH bits: scaled result.
REQ-013 SHALL have port o_out_id, output, clog2(N_REQ) bits: index of the requester that produced o_out_data.

Function
REQ-014 SHALL compute scaled = (a>>>1)+(a>>>3)+(a>>>4), using arithmetic shifts, with each term truncated and the sum wrapping modulo 2^DATA_WIDTH.
REQ-015 SHALL output ~scaled when the granted requester's i_req_neg is 1 (macro absent), and scaled otherwise.
REQ-016 SHALL use a two-state FSM: EMPTY (o_out_valid=0) and FULL (o_out_valid=1).
REQ-017 SHALL define slot free as state EMPTY, or state FULL with i_out_ready=1.
REQ-018 SHALL raise o_req_ready for exactly one requester when the slot is free and any i_req_valid bit is set, and SHALL keep all o_req_ready bits at zero otherwise.
REQ-019 SHALL register a transfer on (i_req_valid[k] & o_req_ready[k]); the result appears on o_out_data/o_out_id with o_out_valid=1 on the next cycle (latency 1).
REQ-020 SHALL arbitrate round-robin: search starts at (last_grant+1) mod N_REQ, and last_grant updates only on a transfer.
REQ-021 SHALL hold o_out_data and o_out_id stable while o_out_valid=1 and i_out_ready=0.
REQ-022 SHALL transition FULL->EMPTY on i_out_ready=1 with no new transfer.
REQ-023 SHALL stay in FULL and load the new result when drain and transfer occur in the same cycle, giving full throughput of one result per cycle.
REQ-024 SHALL transition EMPTY->FULL on a transfer.
REQ-025 SHALL depend combinationally on i_req_valid and i_out_ready for o_req_ready; no output SHALL depend combinationally on i_req_data.

Reset
REQ-026 SHALL apply reset when i_rst_n=0 at a rising edge: state EMPTY, o_out_valid=0, o_out_data=0, o_out_id=0, last_grant=N_REQ-1 so requester 0 wins first.
REQ-027 SHALL drive o_req_ready all zero during the reset cycle.
REQ-028 SHALL discard any held result when reset asserts mid-transfer or during a stall.

Configuration
REQ-029 SHALL, when macro SCALE_TWOS_NEG_EN is defined, negate as two's complement (-scaled, i.e. ~scaled+1, wrapping).
REQ-030 SHALL, without SCALE_TWOS_NEG_EN, negate as one's complement (~scaled) per REQ-015; all other behaviour is identical.

Structure
REQ-031 SHALL place DATA_WIDTH/FRAC defaults, the FSM state typedef (EMPTY, FULL) and the ID width function in shared package scale_pkg.
REQ-032 SHALL isolate the shift-add scaler plus negate in sub-module scale_core (combinational), instantiated once and fed by the granted requester's mux output.

Verification
REQ-033 SHALL check a single request on k=2, data 0x10000, neg=0 -> next cycle o_out_valid=1, o_out_data=0x0B000, o_out_id=2.
REQ-034 SHALL check data 0x10000, neg=1 -> 0xF4FFF without the macro and 0xF5000 with it; data 0xF0000, neg=0 -> 0xF5000.
REQ-035 SHALL check all four requesters valid with i_out_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles, o_out_valid continuously 1.
REQ-036 SHALL check i_out_ready=0 for 3 cycles while FULL -> o_out_data/o_out_id stable, o_req_ready=0; on i_out_ready=1, same-cycle grant and refill.
REQ-037 SHALL check i_rst_n=0 while FULL and stalled -> next cycle o_out_valid=0, o_out_data=0, and the first post-reset grant goes to requester 0.
